// File: rtl/wb_regfile_pkg.sv
// Shared processor constants: datapath widths, register count and the
// control-bit positions that the pipeline registers also use.
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam int CTRL_MEMTOREG_BIT = 3;
    localparam int CTRL_REGWRITE_BIT = 6;

    // Register 0 is hard-wired to zero, so a write to it is never accepted.
    function automatic logic wb_accept(input logic we, input logic [ADDR_W-1:0] rd);
        return we && (rd != {ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_mux.sv
// 2:1 write-back data select; also reused by the forwarding unit.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);

    // sel_i=1 picks in1_i (load data), otherwise in0_i (ALU result).
    always_comb begin
        if (sel_i) begin
            out_o = in1_i;
        end else begin
            out_o = in0_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Flop-based register file with write-back select, write-through bypass on
// the two read ports, a registered debug port and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = wb_regfile_pkg::DATA_W,
    parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = wb_regfile_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] wbResult,
    input  logic [DATA_W-1:0] wbReadData,
    input  logic [ADDR_W-1:0] wbRd,
    input  logic              wbMemToReg,
    input  logic              wbRegWrite,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData,
    output logic [15:0]       wbCount
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] dbg_d;
    logic [15:0]       count_q;
    logic [15:0]       count_d;
    logic [DATA_W-1:0] wdata_s;
    logic              accept_s;
    logic              bypass_s;
    logic [DATA_W-1:0] rf_rd1_s;
    logic [DATA_W-1:0] rf_rd2_s;

    wb_mux #(.W(DATA_W)) u_wb_mux (
        .sel_i (wbMemToReg),
        .in0_i (wbResult),
        .in1_i (wbReadData),
        .out_o (wdata_s)
    );

    assign accept_s = wb_accept(wbRegWrite, wbRd);
    // Bypass is suppressed in reset so the read ports show stored contents.
    assign bypass_s = accept_s && reset_n;

    // Raw array reads with index 0 forced to zero.
    always_comb begin
        if (rs1 == {ADDR_W{1'b0}}) begin
            rf_rd1_s = {DATA_W{1'b0}};
        end else begin
            rf_rd1_s = regs_q[rs1];
        end
        if (rs2 == {ADDR_W{1'b0}}) begin
            rf_rd2_s = {DATA_W{1'b0}};
        end else begin
            rf_rd2_s = regs_q[rs2];
        end
    end

    // Read ports with write-through bypass from the write-back stage.
    always_comb begin
        if (bypass_s && (rs1 == wbRd)) begin
            rdata1 = wdata_s;
        end else begin
            rdata1 = rf_rd1_s;
        end
        if (bypass_s && (rs2 == wbRd)) begin
            rdata2 = wdata_s;
        end else begin
            rdata2 = rf_rd2_s;
        end
    end

    // Next-state for debug read (no bypass) and the write counter.
    always_comb begin
        if (dbgAddr == {ADDR_W{1'b0}}) begin
            dbg_d = {DATA_W{1'b0}};
        end else begin
            dbg_d = regs_q[dbgAddr];
        end
        if (accept_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Storage, debug register and counter; reset wins over a same-edge write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            dbg_q   <= {DATA_W{1'b0}};
            count_q <= 16'd0;
        end else begin
            if (accept_s) begin
                regs_q[wbRd] <= wdata_s;
            end
            dbg_q   <= dbg_d;
            count_q <= count_d;
        end
    end

    assign dbgData = dbg_q;
    assign wbCount = count_q;

endmodule
